// File: rtl/register_file_if.sv
// Bus between decode/writeback and the register file: two read ports and one write port.
// The datapath side uses the master modport and the register file uses the slave modport.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] R1;
  logic [DATA_WIDTH-1:0] R2;

  modport master (
    output A1, A2, WriteReg, ALUResult, RegWrite,
    input  R1, R2
  );

  modport slave (
    input  A1, A2, WriteReg, ALUResult, RegWrite,
    output R1, R2
  );
endinterface

// File: rtl/register_file.sv
// 16x32 register file: two combinational read ports, one synchronous write port, synchronous reset.
// Optional macro REGFILE_BYPASS_EN forwards the pending write data to a read port addressing WriteReg.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  register_file_if.slave   bus
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // Reset clears the whole array and wins over a write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.RegWrite) begin
      r_regs[bus.WriteReg] <= bus.ALUResult;
    end
  end

  assign w_rd1 = r_regs[bus.A1];
  assign w_rd2 = r_regs[bus.A2];

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // Write-first: a read of the register being written sees the incoming data this cycle.
  assign w_fwd1 = bus.RegWrite && !rst && (bus.A1 == bus.WriteReg);
  assign w_fwd2 = bus.RegWrite && !rst && (bus.A2 == bus.WriteReg);

  assign bus.R1 = w_fwd1 ? bus.ALUResult : w_rd1;
  assign bus.R2 = w_fwd2 ? bus.ALUResult : w_rd2;
`else
  assign bus.R1 = w_rd1;
  assign bus.R2 = w_rd2;
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array model of the register contents.
// Build with or without REGFILE_BYPASS_EN; the model follows the same macro.
module tb_register_file;

  logic clk = 1'b0;
  logic rst;
  int   vectorCount = 0;
  int   missCount   = 0;
  bit   checkEn     = 1'b0;

  logic [31:0] model [16];

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expectedRead(input logic [3:0] addr);
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite && !rst && addr == bus.WriteReg) return bus.ALUResult;
`endif
    return model[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveInputs(input logic r, input logic we, input logic [3:0] wa,
                             input logic [31:0] wd, input logic [3:0] a1, input logic [3:0] a2);
    rst           = r;
    bus.RegWrite  = we;
    bus.WriteReg  = wa;
    bus.ALUResult = wd;
    bus.A1        = a1;
    bus.A2        = a2;
  endtask

  // Model takes the edge with the inputs that were present at it, then inputs settle 1 time unit later.
  task automatic stepClock();
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = 32'h0;
      checkEn = 1'b1;
    end else if (bus.RegWrite) begin
      model[bus.WriteReg] = bus.ALUResult;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [3:0] wa,
                               input logic [31:0] wd, input logic [3:0] a1, input logic [3:0] a2);
    driveInputs(r, we, wa, wd, a1, a2);
    stepClock();
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("R1", bus.R1, expectedRead(bus.A1));
      checkOutput("R2", bus.R2, expectedRead(bus.A2));
    end
  end

  initial begin
    driveInputs(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'd9, 32'hCAFEF00D, 4'd9, 4'd9);

    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'(a), 4'(15 - a));
      checkOutput("rstR1", bus.R1, 32'h0);
      checkOutput("rstR2", bus.R2, 32'h0);
    end

    for (int n = 0; n < 100; n++) begin
      applyStimulus(1'b0, 1'b0, 4'd2, 32'h0000000F, 4'd2, 4'd7);
      checkOutput("wrDisR1", bus.R1, 32'h0);
      checkOutput("wrDisR2", bus.R2, 32'h0);
    end

    applyStimulus(1'b0, 1'b1, 4'd2, 32'h0000000F, 4'd2, 4'd7);
    checkOutput("wrEnR1", bus.R1, 32'h0000000F);
    checkOutput("wrEnR2", bus.R2, 32'h0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0, 1'b0, 4'd2, 32'h0000000F, 4'd2, 4'd7);
      checkOutput("wrHoldR1", bus.R1, 32'h0000000F);
    end

    applyStimulus(1'b0, 1'b1, 4'd15, 32'hDEADBEEF, 4'd15, 4'd15);
    applyStimulus(1'b0, 1'b1, 4'd0, 32'h12345678, 4'd15, 4'd15);
    checkOutput("dualR1", bus.R1, 32'hDEADBEEF);
    checkOutput("dualR2", bus.R2, 32'hDEADBEEF);
    driveInputs(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd15);
    #1;
    checkOutput("reg0R1", bus.R1, 32'h12345678);
    stepClock();

    applyStimulus(1'b1, 1'b1, 4'd3, 32'h000000AA, 4'd3, 4'd3);
    checkOutput("rstPrioR1", bus.R1, 32'h0);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 1'b0, 4'd3, 32'h000000AA, 4'(a), 4'd3);
      checkOutput("rstAllR1", bus.R1, 32'h0);
    end

    applyStimulus(1'b0, 1'b1, 4'd5, 32'h00000001, 4'd0, 4'd0);
    driveInputs(1'b0, 1'b1, 4'd5, 32'h00000055, 4'd5, 4'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypassPre", bus.R1, 32'h00000055);
`else
    checkOutput("bypassPre", bus.R1, 32'h00000001);
`endif
    stepClock();
    driveInputs(1'b0, 1'b0, 4'd5, 32'h0, 4'd5, 4'd0);
    #1;
    checkOutput("bypassPost", bus.R1, 32'h00000055);
    stepClock();

    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom),
                    $urandom, 4'($urandom), 4'($urandom));
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
